// File: rtl/uart_config_loader_if.sv
// Bundle of the serial lines, error clear and configuration outputs of uart_config_loader.
//   master : the host side (board pins / user design), drives uart_rx and err_clr
//   slave  : the loader, drives uart_tx, config_bits, config_valid, config_done, err_status
interface uart_config_loader_if #(
  parameter int unsigned CFG_WIDTH = 52
);
  logic                 uart_rx;
  logic                 err_clr;
  logic                 uart_tx;
  logic [CFG_WIDTH-1:0] config_bits;
  logic                 config_valid;
  logic                 config_done;
  logic [3:0]           err_status;

  modport master (
    output uart_rx,
    output err_clr,
    input  uart_tx,
    input  config_bits,
    input  config_valid,
    input  config_done,
    input  err_status
  );

  modport slave (
    input  uart_rx,
    input  err_clr,
    output uart_tx,
    output config_bits,
    output config_valid,
    output config_done,
    output err_status
  );
endinterface

// File: rtl/uart_config_loader.sv
// UART configuration loader. Receives packets of the form
//   SYNC_BYTE, NUM_BYTES payload bytes (MSB first), XOR checksum of the payload
// applies the low CFG_WIDTH bits of a good payload to config_bits and answers every packet
// with ACK_BYTE or NAK_BYTE on uart_tx. A stalled packet is dropped silently after
// TIMEOUT_BITS idle bit times.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : uart_config_loader_if.slave
//          uart_rx (in), err_clr (in), uart_tx (out), config_bits (out),
//          config_valid (out, 1-cycle pulse), config_done (out, sticky),
//          err_status (out, sticky {timeout, pad, checksum, framing})
module uart_config_loader #(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned BAUD_RATE    = 115_200,
  parameter int unsigned CFG_WIDTH    = 52,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_BITS = 32,
  parameter logic [7:0]  ACK_BYTE     = 8'h06,
  parameter logic [7:0]  NAK_BYTE     = 8'h15
) (
  input logic                 clk,
  input logic                 rst,
  uart_config_loader_if.slave bus
);

  localparam int unsigned BAUD_DIV  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned NUM_BYTES = (CFG_WIDTH + 7) / 8;
  localparam int unsigned PAD       = NUM_BYTES * 8 - CFG_WIDTH;
  localparam int unsigned SHW       = NUM_BYTES * 8;
  localparam int unsigned TO_CYCLES = TIMEOUT_BITS * BAUD_DIV;
  localparam int unsigned BAUD_W    = $clog2(BAUD_DIV + 1);
  localparam int unsigned CNT_W     = $clog2(NUM_BYTES + 1);
  localparam int unsigned TO_W      = $clog2(TO_CYCLES + 1);
  // Bits of the first payload byte that lie above CFG_WIDTH and must be zero.
  localparam logic [7:0]  PAD_MASK  = 8'(16'hFF00 >> PAD);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {PSync, PData, PChk, PApply} pkt_state_e;
  typedef enum logic [0:0] {TxIdle, TxRun} tx_state_e;

  // Input synchroniser
  logic rx_meta_q, rx_sync_q;

  // Byte receiver
  rx_state_e         rx_state_q, rx_state_d;
  logic [BAUD_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic              byte_strobe_q, byte_strobe_d;
  logic              byte_abort_q, byte_abort_d;

  // Packet FSM
  pkt_state_e           pkt_state_q, pkt_state_d;
  logic [SHW-1:0]       shift_q, shift_d;
  logic [7:0]           xor_q, xor_d;
  logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic                 pad_viol_q, pad_viol_d;
  logic                 good_q, good_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [CFG_WIDTH-1:0] config_bits_q, config_bits_d;
  logic                 config_valid_q, config_valid_d;
  logic                 config_done_q, config_done_d;
  logic [3:0]           err_q, err_d;
  logic                 pkt_good;
  logic                 tx_req;
  logic [7:0]           tx_byte;

  // Transmitter
  tx_state_e         tx_state_q, tx_state_d;
  logic [BAUD_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]        tx_bits_q, tx_bits_d;
  logic [8:0]        tx_shift_q, tx_shift_d;
  logic              tx_q, tx_d;

  // Byte receiver next state
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    byte_strobe_d = 1'b0;
    byte_abort_d  = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (!rx_sync_q) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
        end
      end
      RxStart: begin
        if (rx_cnt_q == BAUD_W'(BAUD_DIV / 2 - 1)) begin
          // A start bit that is gone by mid-bit was a glitch.
          rx_state_d = rx_sync_q ? RxIdle : RxData;
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (rx_cnt_q == BAUD_W'(BAUD_DIV - 1)) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == BAUD_W'(BAUD_DIV - 1)) begin
          rx_cnt_d      = '0;
          byte_strobe_d = rx_sync_q;
          byte_abort_d  = !rx_sync_q;
          rx_state_d    = RxIdle;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  assign pkt_good = (rx_shift_q == xor_q) && !pad_viol_q;

  // Packet FSM next state, configuration and error flags
  always_comb begin
    pkt_state_d    = pkt_state_q;
    shift_d        = shift_q;
    xor_d          = xor_q;
    byte_cnt_d     = byte_cnt_q;
    pad_viol_d     = pad_viol_q;
    good_d         = good_q;
    to_cnt_d       = '0;
    config_bits_d  = config_bits_q;
    config_valid_d = 1'b0;
    config_done_d  = config_done_q;
    // Clear first so that a set in the same cycle wins.
    err_d          = bus.err_clr ? 4'b0000 : err_q;
    tx_req         = 1'b0;
    tx_byte        = NAK_BYTE;
    if (byte_abort_d) err_d[0] = 1'b1;

    unique case (pkt_state_q)
      PSync: begin
        if (byte_strobe_q && rx_shift_q == SYNC_BYTE) begin
          pkt_state_d = PData;
          shift_d     = '0;
          xor_d       = '0;
          byte_cnt_d  = '0;
          pad_viol_d  = 1'b0;
        end
      end
      PData: begin
        if (byte_strobe_q) begin
          shift_d = (shift_q << 8) | SHW'(rx_shift_q);
          xor_d   = xor_q ^ rx_shift_q;
          if (byte_cnt_q == '0 && (rx_shift_q & PAD_MASK) != 8'h00) pad_viol_d = 1'b1;
          if (byte_cnt_q != CNT_W'(NUM_BYTES)) byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == CNT_W'(NUM_BYTES - 1)) pkt_state_d = PChk;
        end
      end
      PChk: begin
        // Results become visible on the P_APPLY cycle.
        if (byte_strobe_q) begin
          good_d      = pkt_good;
          pkt_state_d = PApply;
          if (pkt_good) begin
            config_bits_d  = shift_q[CFG_WIDTH-1:0];
            config_valid_d = 1'b1;
            config_done_d  = 1'b1;
          end else begin
            if (rx_shift_q != xor_q) err_d[1] = 1'b1;
            if (pad_viol_q) err_d[2] = 1'b1;
          end
        end
      end
      PApply: begin
        tx_req      = 1'b1;
        tx_byte     = good_q ? ACK_BYTE : NAK_BYTE;
        pkt_state_d = PSync;
      end
      default: pkt_state_d = PSync;
    endcase

    if (pkt_state_q != PSync && byte_abort_q) begin
      pkt_state_d = PSync;
      tx_req      = 1'b1;
      tx_byte     = NAK_BYTE;
    end

    // Idle-gap watchdog; restarts whenever the receiver leaves RX_IDLE.
    if ((pkt_state_q == PData || pkt_state_q == PChk) && rx_state_q == RxIdle) begin
      if (to_cnt_q == TO_W'(TO_CYCLES - 1)) begin
        err_d[3]    = 1'b1;
        pkt_state_d = PSync;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  // Transmitter next state; a request while busy is dropped.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bits_d  = tx_bits_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    unique case (tx_state_q)
      TxIdle: begin
        tx_d = 1'b1;
        if (tx_req) begin
          tx_state_d = TxRun;
          tx_d       = 1'b0;
          tx_shift_d = {1'b1, tx_byte};
          tx_bits_d  = 4'd9;
          tx_cnt_d   = '0;
        end
      end
      TxRun: begin
        if (tx_cnt_q == BAUD_W'(BAUD_DIV - 1)) begin
          tx_cnt_d = '0;
          if (tx_bits_q == 4'd0) begin
            tx_state_d = TxIdle;
            tx_d       = 1'b1;
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = {1'b1, tx_shift_q[8:1]};
            tx_bits_d  = tx_bits_q - 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q      <= 1'b1;
      rx_sync_q      <= 1'b1;
      rx_state_q     <= RxIdle;
      rx_cnt_q       <= '0;
      rx_bit_q       <= '0;
      rx_shift_q     <= '0;
      byte_strobe_q  <= 1'b0;
      byte_abort_q   <= 1'b0;
      pkt_state_q    <= PSync;
      shift_q        <= '0;
      xor_q          <= '0;
      byte_cnt_q     <= '0;
      pad_viol_q     <= 1'b0;
      good_q         <= 1'b0;
      to_cnt_q       <= '0;
      config_bits_q  <= '0;
      config_valid_q <= 1'b0;
      config_done_q  <= 1'b0;
      err_q          <= '0;
      tx_state_q     <= TxIdle;
      tx_cnt_q       <= '0;
      tx_bits_q      <= '0;
      tx_shift_q     <= '1;
      tx_q           <= 1'b1;
    end else begin
      rx_meta_q      <= bus.uart_rx;
      rx_sync_q      <= rx_meta_q;
      rx_state_q     <= rx_state_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_bit_q       <= rx_bit_d;
      rx_shift_q     <= rx_shift_d;
      byte_strobe_q  <= byte_strobe_d;
      byte_abort_q   <= byte_abort_d;
      pkt_state_q    <= pkt_state_d;
      shift_q        <= shift_d;
      xor_q          <= xor_d;
      byte_cnt_q     <= byte_cnt_d;
      pad_viol_q     <= pad_viol_d;
      good_q         <= good_d;
      to_cnt_q       <= to_cnt_d;
      config_bits_q  <= config_bits_d;
      config_valid_q <= config_valid_d;
      config_done_q  <= config_done_d;
      err_q          <= err_d;
      tx_state_q     <= tx_state_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_bits_q      <= tx_bits_d;
      tx_shift_q     <= tx_shift_d;
      tx_q           <= tx_d;
    end
  end

  assign bus.uart_tx      = tx_q;
  assign bus.config_bits  = config_bits_q;
  assign bus.config_valid = config_valid_q;
  assign bus.config_done  = config_done_q;
  assign bus.err_status   = err_q;

endmodule

// File: tb/tb_uart_config_loader.sv
// Self-checking bench for uart_config_loader at BAUD_DIV = 10, CFG_WIDTH = 52.
// Expected responses are queued when a packet is sent and popped when the uart_tx decoder
// produces a byte; expected configuration words come from a byte-concatenation model.
module tb_uart_config_loader;
  localparam int unsigned CLK_FREQ  = 1_000_000;
  localparam int unsigned BAUD_RATE = 100_000;
  localparam int unsigned CFG_WIDTH = 52;
  localparam int unsigned BD        = 10;
  localparam logic [7:0]  ACK       = 8'h06;
  localparam logic [7:0]  NAK       = 8'h15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_config_loader_if #(.CFG_WIDTH(CFG_WIDTH)) bus ();

  uart_config_loader #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE),
    .CFG_WIDTH(CFG_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int                   n_checks = 0;
  int                   n_pass   = 0;
  int                   valid_cnt = 0;
  logic [7:0]           tx_got[$];
  logic [7:0]           tx_exp[$];
  logic [7:0]           pl[0:6];
  logic [CFG_WIDTH-1:0] cfg_exp;

  // uart_tx decoder
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.uart_tx === 1'b0) begin
        repeat (BD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          b[i] = bus.uart_tx;
        end
        repeat (BD) @(negedge clk);
        tx_got.push_back(bus.uart_tx === 1'b1 ? b : 8'h00);
      end
    end
  end

  always @(negedge clk) if (bus.config_valid === 1'b1) valid_cnt++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  function automatic logic [CFG_WIDTH-1:0] cfg_of();
    logic [55:0] acc = '0;
    for (int i = 0; i < 7; i++) acc = {acc[47:0], pl[i]};
    return acc[CFG_WIDTH-1:0];
  endfunction

  function automatic logic [7:0] xor_of();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 7; i++) x = x ^ pl[i];
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    @(negedge clk);
    bus.uart_rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rx = b[i];
      repeat (BD) @(negedge clk);
    end
    bus.uart_rx = stop_val;
    repeat (BD) @(negedge clk);
    bus.uart_rx = 1'b1;
  endtask

  task automatic send_packet(input logic [7:0] chk);
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 7; i++) send_byte(pl[i], 1'b1);
    send_byte(chk, 1'b1);
  endtask

  task automatic wait_tx(output logic ok, output logic [7:0] b);
    ok = 1'b0;
    b  = 8'h00;
    for (int i = 0; i < 800 && !ok; i++) begin
      @(negedge clk);
      if (tx_got.size() > 0) begin
        b  = tx_got.pop_front();
        ok = 1'b1;
      end
    end
  endtask

  task automatic clear_err();
    @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_pl(input logic [55:0] v);
    for (int i = 0; i < 7; i++) pl[i] = v[55-8*i -: 8];
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.uart_rx = 1'b1;
    bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.uart_tx !== 1'b1) $display("FAIL reset_tx: got %b, expected 1", bus.uart_tx);
    else n_pass++;
    n_checks++;
    if (bus.config_bits !== '0) $display("FAIL reset_cfg: got %h, expected 0", bus.config_bits);
    else n_pass++;
    n_checks++;
    if (bus.config_done !== 1'b0 || bus.config_valid !== 1'b0)
      $display("FAIL reset_flags: got done %b valid %b, expected 0 0",
               bus.config_done, bus.config_valid);
    else n_pass++;
    n_checks++;
    if (bus.err_status !== 4'b0000) $display("FAIL reset_err: got %b, expected 0000",
                                             bus.err_status);
    else n_pass++;
  endtask

  task automatic test_good_packet();
    logic ok;
    logic [7:0] got, exp;
    int v0;
    v0 = valid_cnt;
    set_pl(56'h0F_12_34_56_78_9A_BC);
    cfg_exp = cfg_of();
    tx_exp.push_back(ACK);
    send_packet(xor_of());
    wait_tx(ok, got);
    exp = tx_exp.pop_front();
    n_checks++;
    if (!ok || got !== exp) $display("FAIL good_resp: got %h (seen %b), expected %h", got, ok, exp);
    else n_pass++;
    n_checks++;
    if (bus.config_bits !== 52'hF_1234_5678_9ABC || bus.config_bits !== cfg_exp)
      $display("FAIL good_cfg: got %h, expected %h", bus.config_bits, 52'hF_1234_5678_9ABC);
    else n_pass++;
    n_checks++;
    if (valid_cnt - v0 != 1) $display("FAIL good_valid: got %0d pulses, expected 1", valid_cnt - v0);
    else n_pass++;
    n_checks++;
    if (bus.config_done !== 1'b1 || bus.err_status !== 4'b0000)
      $display("FAIL good_status: got done %b err %b, expected 1 0000",
               bus.config_done, bus.err_status);
    else n_pass++;
  endtask

  task automatic test_bad_checksum();
    logic ok;
    logic [7:0] got, exp;
    int v0;
    v0 = valid_cnt;
    set_pl(56'h0F_12_34_56_78_9A_BC);
    tx_exp.push_back(NAK);
    send_packet(8'h22);
    wait_tx(ok, got);
    exp = tx_exp.pop_front();
    n_checks++;
    if (!ok || got !== exp) $display("FAIL chk_resp: got %h (seen %b), expected %h", got, ok, exp);
    else n_pass++;
    n_checks++;
    if (bus.config_bits !== cfg_exp || valid_cnt != v0)
      $display("FAIL chk_cfg: got %h (%0d pulses), expected %h (0 pulses)",
               bus.config_bits, valid_cnt - v0, cfg_exp);
    else n_pass++;
    n_checks++;
    if (bus.err_status !== 4'b0010) $display("FAIL chk_err: got %b, expected 0010", bus.err_status);
    else n_pass++;
    clear_err();
  endtask

  task automatic test_pad_violation();
    logic ok;
    logic [7:0] got, exp;
    set_pl(56'h1F_12_34_56_78_9A_BC);
    n_checks++;
    if (xor_of() !== 8'h31) $display("FAIL pad_model: got %h, expected 31", xor_of());
    else n_pass++;
    tx_exp.push_back(NAK);
    send_packet(xor_of());
    wait_tx(ok, got);
    exp = tx_exp.pop_front();
    n_checks++;
    if (!ok || got !== exp) $display("FAIL pad_resp: got %h (seen %b), expected %h", got, ok, exp);
    else n_pass++;
    n_checks++;
    if (bus.err_status !== 4'b0100 || bus.config_bits !== cfg_exp)
      $display("FAIL pad_err: got err %b cfg %h, expected 0100 %h",
               bus.err_status, bus.config_bits, cfg_exp);
    else n_pass++;
    clear_err();
  endtask

  task automatic test_framing();
    logic ok;
    logic [7:0] got, exp;
    tx_exp.push_back(NAK);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h0F, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b0);
    repeat (3 * BD) @(negedge clk);
    wait_tx(ok, got);
    exp = tx_exp.pop_front();
    n_checks++;
    if (!ok || got !== exp) $display("FAIL frm_resp: got %h (seen %b), expected %h", got, ok, exp);
    else n_pass++;
    n_checks++;
    if (bus.err_status !== 4'b0001) $display("FAIL frm_err: got %b, expected 0001", bus.err_status);
    else n_pass++;
    set_pl(56'h0A_BB_CC_DD_EE_FF_11);
    cfg_exp = cfg_of();
    tx_exp.push_back(ACK);
    send_packet(xor_of());
    wait_tx(ok, got);
    exp = tx_exp.pop_front();
    n_checks++;
    if (!ok || got !== exp) $display("FAIL frm_rec_resp: got %h (seen %b), expected %h",
                                     got, ok, exp);
    else n_pass++;
    n_checks++;
    if (bus.config_bits !== cfg_exp || bus.err_status !== 4'b0001)
      $display("FAIL frm_rec_cfg: got %h err %b, expected %h 0001",
               bus.config_bits, bus.err_status, cfg_exp);
    else n_pass++;
    clear_err();
    n_checks++;
    if (bus.err_status !== 4'b0000) $display("FAIL err_clr: got %b, expected 0000",
                                             bus.err_status);
    else n_pass++;
  endtask

  task automatic test_timeout();
    logic ok;
    logic [7:0] got, exp;
    int v0;
    v0 = valid_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h0F, 1'b1);
    send_byte(8'h12, 1'b1);
    repeat (250) @(negedge clk);
    n_checks++;
    if (bus.err_status[3] !== 1'b0) $display("FAIL to_early: got %b, expected 0", bus.err_status[3]);
    else n_pass++;
    repeat (80) @(negedge clk);
    n_checks++;
    if (bus.err_status !== 4'b1000) $display("FAIL to_err: got %b, expected 1000", bus.err_status);
    else n_pass++;
    repeat (150) @(negedge clk);
    n_checks++;
    if (tx_got.size() != 0 || valid_cnt != v0)
      $display("FAIL to_silent: got %0d responses %0d pulses, expected 0 0",
               tx_got.size(), valid_cnt - v0);
    else n_pass++;
    set_pl(56'h03_01_02_03_04_05_06);
    cfg_exp = cfg_of();
    tx_exp.push_back(ACK);
    send_packet(xor_of());
    wait_tx(ok, got);
    exp = tx_exp.pop_front();
    n_checks++;
    if (!ok || got !== exp) $display("FAIL to_rec_resp: got %h (seen %b), expected %h",
                                     got, ok, exp);
    else n_pass++;
    n_checks++;
    if (bus.config_bits !== cfg_exp) $display("FAIL to_rec_cfg: got %h, expected %h",
                                              bus.config_bits, cfg_exp);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic ok;
    logic [7:0] got, exp;
    int v0;
    v0 = valid_cnt;
    set_pl(56'h05_55_AA_00_FF_01_80);
    tx_exp.push_back(ACK);
    send_packet(xor_of());
    set_pl(56'h0C_DE_AD_BE_EF_12_34);
    cfg_exp = cfg_of();
    tx_exp.push_back(ACK);
    send_packet(xor_of());
    for (int k = 0; k < 2; k++) begin
      wait_tx(ok, got);
      exp = tx_exp.pop_front();
      n_checks++;
      if (!ok || got !== exp) $display("FAIL b2b_resp%0d: got %h (seen %b), expected %h",
                                       k, got, ok, exp);
      else n_pass++;
    end
    n_checks++;
    if (bus.config_bits !== cfg_exp || valid_cnt - v0 != 2)
      $display("FAIL b2b_cfg: got %h (%0d pulses), expected %h (2 pulses)",
               bus.config_bits, valid_cnt - v0, cfg_exp);
    else n_pass++;
  endtask

  task automatic test_reset_mid_packet();
    logic ok;
    logic [7:0] got, exp;
    n_checks++;
    if (bus.config_done !== 1'b1) $display("FAIL pre_rst_done: got %b, expected 1",
                                           bus.config_done);
    else n_pass++;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h0F, 1'b1);
    send_byte(8'h12, 1'b1);
    @(negedge clk);
    bus.uart_rx = 1'b0;
    repeat (35) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.config_bits !== '0 || bus.config_done !== 1'b0 || bus.config_valid !== 1'b0 ||
        bus.err_status !== 4'b0000 || bus.uart_tx !== 1'b1)
      $display("FAIL mid_rst: got cfg %h done %b valid %b err %b tx %b, expected 0 0 0 0000 1",
               bus.config_bits, bus.config_done, bus.config_valid, bus.err_status, bus.uart_tx);
    else n_pass++;
    bus.uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    set_pl(56'h01_23_45_67_89_AB_CD);
    cfg_exp = cfg_of();
    tx_exp.push_back(ACK);
    send_packet(xor_of());
    wait_tx(ok, got);
    exp = tx_exp.pop_front();
    n_checks++;
    if (!ok || got !== exp || bus.config_bits !== cfg_exp)
      $display("FAIL post_rst: got resp %h cfg %h, expected %h %h", got, bus.config_bits,
               exp, cfg_exp);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_checksum();
    test_pad_violation();
    test_framing();
    test_timeout();
    test_back_to_back();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_config_loader.md
# uart_config_loader

Parametrised UART configuration loader, the successor of the fixed 52-bit loader. It receives a framed packet over a UART line (sync byte, payload, XOR checksum) and applies a `CFG_WIDTH`-bit configuration word. It accepts repeated reloads and reports sticky error status. Every packet is answered with an ACK or NAK byte on a UART transmit line. It sits between the board UART pins and the configuration inputs of the user design.

## Interface

**Parameters**
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 115_200: line rate. `BAUD_DIV = CLK_FREQ/BAUD_RATE`, and `BAUD_DIV` must be ≥ 4.
- `CFG_WIDTH`, default 52: configuration width, 1..256. `NUM_BYTES = ceil(CFG_WIDTH/8)` and `PAD = NUM_BYTES*8 - CFG_WIDTH`.
- `SYNC_BYTE`, default 8'hA5: packet start marker.
- `TIMEOUT_BITS`, default 32: maximum idle gap between packet bytes, in bit times.
- `ACK_BYTE` / `NAK_BYTE`, defaults 8'h06 / 8'h15.

**Ports**
- `clk` input, 1: system clock.
- `rst` input, 1: asynchronous, active-high reset.
- `uart_rx` input, 1: serial input, asynchronous to `clk`, idle high.
- `err_clr` input, 1: single-cycle pulse that clears `err_status`.
- `uart_tx` output, 1: serial ACK/NAK output, idle high.
- `config_bits` output, `CFG_WIDTH`: applied configuration.
- `config_valid` output, 1: one-cycle pulse when `config_bits` is updated.
- `config_done` output, 1: high once at least one packet has been applied.
- `err_status` output, 4: sticky error flags, `{timeout, pad, checksum, framing}`.

## Operation

- **Reset.** All outputs return to their reset values: `uart_tx`=1, `config_bits`=0, `config_valid`=0, `config_done`=0, `err_status`=0. The receiver and packet FSMs go to idle. This applies mid-packet and mid-ACK as well: the partial packet is lost and `uart_tx` returns to high.
- **Input sync.** `uart_rx` passes through a 2-flop synchroniser; both flops reset to 1.
- **Byte receiver.** States: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE → RX_START when the synchronised input is low.
  - RX_START: sample at count `BAUD_DIV/2 - 1`. If the line is low, go to RX_DATA. If it is high, treat it as a glitch: return to RX_IDLE with no error.
  - RX_DATA: sample 8 bits LSB-first, one every `BAUD_DIV` cycles, then go to RX_STOP.
  - RX_STOP: sample after `BAUD_DIV` cycles. If the line is high, pulse `byte_strobe` for 1 cycle. If it is low, set `framing` and pulse `byte_abort`. Both outcomes return to RX_IDLE.
- **Packet FSM.** States: P_SYNC, P_DATA, P_CHK, P_APPLY.
  - P_SYNC: non-sync bytes are silently discarded. `SYNC_BYTE` → P_DATA, which clears the shift register, the XOR accumulator and the byte counter.
  - P_DATA: shift each byte in MSB-first and XOR it into the accumulator. The first payload byte must have its top `PAD` bits at zero; if not, set the pad-violation marker for this packet. After `NUM_BYTES` bytes, go to P_CHK.
  - P_CHK: the received byte is the checksum. The packet is good if the checksum equals the accumulator and no pad violation occurred. Go to P_APPLY.
  - P_APPLY (1 cycle):
    - Good packet: load `config_bits` from the low `CFG_WIDTH` bits of the shift register, pulse `config_valid`, set `config_done`, request an ACK.
    - Bad packet: set `checksum` and/or `pad`, request a NAK, and leave `config_bits` unchanged.
    - Then go to P_SYNC.
  - `byte_abort` in any state except P_SYNC: go to P_SYNC and request a NAK.
- **Timeout.** In P_DATA or P_CHK, if the receiver stays in RX_IDLE for `TIMEOUT_BITS*BAUD_DIV` consecutive cycles: set `timeout`, go to P_SYNC, and send no response.
- **Sync byte inside the payload** is treated as ordinary data; there is no resynchronisation.
- **Reload.** Packets are accepted indefinitely. `config_done` stays high once set, and each good packet overwrites `config_bits`.
- **Error flags.** `err_status` bits are sticky until `err_clr` or `rst`. If `err_clr` and a set event occur in the same cycle, the set wins. Error flags do not block reception.
- **Transmitter.** Sends 1 start bit, 8 data bits LSB-first and 1 stop bit, each lasting `BAUD_DIV` cycles. A response takes 10 bit times, and any packet takes at least `(NUM_BYTES+2)*10` bit times, so the transmitter is never busy when a new request arrives. If it is busy anyway, the request is dropped.

## Timing

- `byte_strobe` is asserted on the cycle after the stop-bit sample.
- P_APPLY, and therefore `config_valid`, the `config_bits` update and the `err_status` update, occurs 1 cycle after the checksum byte's `byte_strobe`.
- `uart_tx` falls (start bit) 1 cycle after P_APPLY, or 1 cycle after a `byte_abort` NAK.
- The `framing` flag is set on the same cycle as `byte_abort`.
- Timeout is counted in whole cycles. The flag is set on the cycle the counter reaches `TIMEOUT_BITS*BAUD_DIV - 1`. Any start-bit detection resets the counter.
- All arithmetic is unsigned. Counter widths use `$clog2` of their maximum value + 1, and the byte counter saturates at `NUM_BYTES`.

## Test plan

All scenarios use `CLK_FREQ`=1_000_000, `BAUD_RATE`=100_000 (so `BAUD_DIV`=10) and `CFG_WIDTH`=52 (so `NUM_BYTES`=7, `PAD`=4).

1. **Good packet.** Send A5 0F 12 34 56 78 9A BC 21.
   - `config_bits`=52'hF_1234_5678_9ABC.
   - One `config_valid` pulse, `config_done`=1.
   - `uart_tx` carries 0x06; `err_status`=0.
2. **Bad checksum.** Same packet with checksum 0x22.
   - `config_bits` unchanged, no `config_valid`.
   - `err_status`=4'b0010; `uart_tx` sends 0x15.
3. **Pad violation.** First payload byte 0x1F, checksum recomputed as 0x31.
   - NAK on `uart_tx`; `err_status[2]`=1; `config_bits` unchanged.
4. **Framing and recovery.** Force the stop bit low on the 3rd payload byte.
   - `err_status[0]`=1 and a NAK is sent.
   - A following valid packet is applied.
   - `err_clr` then returns `err_status` to 0.
5. **Timeout.** Send A5 0F 12, then idle for 320 cycles.
   - `err_status[3]`=1, no response.
   - A full packet afterwards is applied correctly.
6. **Reload and reset.** Apply two packets back-to-back: `config_bits` follows the second. Then assert `rst` mid-packet: all outputs return to 0 and `uart_tx`=1.
